// File: rtl/sar_afe_pkg.sv
// Shared types and constants for the SAR analog-front-end emulator.
// The LFSR constants are only consumed when SAR_AFE_DITHER_EN is defined.
package sar_afe_pkg;

    typedef enum logic [1:0] {IDLE, TRACK, HOLD, CHECK} afe_state_e;

    localparam int          ERR_CNT_W = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sar_afe_cmp_pipe.sv
// Comparator model: raw unsigned held >= dac, then a CmpLatency-deep delay line.
// The delay-line input is forced low while the front end is not holding.
module sar_afe_cmp_pipe #(
    parameter int Width      = 6,
    parameter int CmpLatency = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] held,
    input  logic [Width-1:0] dac,
    input  logic             force_zero,
    output logic             cmp
);

    logic raw;
    assign raw = (held >= dac);

    generate
        if (CmpLatency == 0) begin : g_comb
            // A zero-latency comparator has no stage to force, so raw is visible everywhere.
            logic unused_force;
            assign unused_force = force_zero;
            assign cmp = raw;
        end else begin : g_pipe
            logic [CmpLatency-1:0] vld_pipe;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[0] <= raw & ~force_zero;
                    for (int i = 1; i < CmpLatency; i++) vld_pipe[i] <= vld_pipe[i-1];
                end
            end
            assign cmp = vld_pipe[CmpLatency-1];
        end
    endgenerate

endmodule

// File: rtl/sar_afe_emulator.sv
// Digital stand-in for the S/H + DAC + comparator seen by a SAR controller, with result checking.
// Define SAR_AFE_DITHER_EN to add +/-1 LSB LFSR dither on the held sample and a +/-1 check tolerance.
module sar_afe_emulator
    import sar_afe_pkg::*;
#(
    parameter int Width      = 6,
    parameter int CmpLatency = 1,
    parameter int MaxCycles  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [Width-1:0]     vin_i,
    input  logic                 sample_i,
    input  logic [Width-1:0]     dac_i,
    input  logic                 eoc_i,
    input  logic [Width-1:0]     result_i,
    output logic                 cmp_o,
    output logic [Width-1:0]     held_o,
    output logic                 busy_o,
    output logic                 match_o,
    output logic                 mismatch_o,
    output logic                 timeout_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int CntW = $clog2(MaxCycles + 1);

    afe_state_e      state, state_nx;
    logic            eoc_q, eoc_rise;
    logic [CntW-1:0] cnt;
    logic [Width-1:0] hold_val;
    logic            result_ok;
    logic            match_nx, mismatch_nx, timeout_nx;

    assign eoc_rise = eoc_i & ~eoc_q;
    assign busy_o   = (state == HOLD);

`ifdef SAR_AFE_DITHER_EN
    logic [15:0]      lfsr;
    logic [Width-1:0] diff;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    // 00 -> -1, 11 -> +1, otherwise 0; clamped at the code range ends
    always_comb begin
        hold_val = vin_i;
        if (lfsr[1:0] == 2'b00 && vin_i != '0)      hold_val = vin_i - 1'b1;
        else if (lfsr[1:0] == 2'b11 && vin_i != '1) hold_val = vin_i + 1'b1;
    end

    assign diff      = (result_i >= held_o) ? (result_i - held_o) : (held_o - result_i);
    assign result_ok = (diff <= Width'(1));
`else
    assign hold_val  = vin_i;
    assign result_ok = (result_i == held_o);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        match_nx    = 1'b0;
        mismatch_nx = 1'b0;
        timeout_nx  = 1'b0;
        case (state)
            IDLE:  if (sample_i) state_nx = TRACK;
            TRACK: if (!sample_i) state_nx = HOLD;
            HOLD: begin
                if (eoc_rise)      state_nx = CHECK;
                else if (sample_i) state_nx = TRACK;
                else if (cnt == CntW'(MaxCycles - 1)) begin
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                end
            end
            CHECK: begin
                match_nx    = result_ok;
                mismatch_nx = ~result_ok;
                state_nx    = sample_i ? TRACK : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eoc_q      <= 1'b0;
            held_o     <= '0;
            cnt        <= '0;
            match_o    <= 1'b0;
            mismatch_o <= 1'b0;
            timeout_o  <= 1'b0;
            err_cnt_o  <= '0;
        end else begin
            eoc_q      <= eoc_i;
            match_o    <= match_nx;
            mismatch_o <= mismatch_nx;
            timeout_o  <= timeout_nx;
            // the cycle sample_i drops is the last tracked cycle and the hold point
            if (state == TRACK) held_o <= sample_i ? vin_i : hold_val;
            cnt <= (state == HOLD) ? cnt + 1'b1 : '0;
            if ((mismatch_nx || timeout_nx) && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

    sar_afe_cmp_pipe #(
        .Width      (Width),
        .CmpLatency (CmpLatency)
    ) u_cmp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .held       (held_o),
        .dac        (dac_i),
        .force_zero (state == IDLE || state == TRACK),
        .cmp        (cmp_o)
    );

endmodule

// File: tb/tb_sar_afe_emulator.sv
// Directed bench for sar_afe_emulator: a SAR search drives the loop, a scoreboard checks pulses.
// A second instance with CmpLatency=3 shares the inputs to check comparator delay.
module tb_sar_afe_emulator;

    localparam int W = 6;
    localparam logic [2:0] K_MATCH = 3'b001;
    localparam logic [2:0] K_MIS   = 3'b010;
    localparam logic [2:0] K_TO    = 3'b100;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] vin, dac, result;
    logic         sample, eoc;
    logic         cmp, busy, match, mismatch, timeout;
    logic [W-1:0] held;
    logic [7:0]   err_cnt;
    logic         cmp3, busy3, match3, mismatch3, timeout3;
    logic [W-1:0] held3;
    logic [7:0]   err3;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] err;
        string      name;
    } exp_t;
    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] exp_err;
    logic [W-1:0] code;

    always #5 clk = ~clk;

    sar_afe_emulator #(.Width(W), .CmpLatency(1), .MaxCycles(64)) dut (
        .clk_i(clk), .rst_i(rst), .vin_i(vin), .sample_i(sample), .dac_i(dac),
        .eoc_i(eoc), .result_i(result), .cmp_o(cmp), .held_o(held), .busy_o(busy),
        .match_o(match), .mismatch_o(mismatch), .timeout_o(timeout), .err_cnt_o(err_cnt)
    );

    sar_afe_emulator #(.Width(W), .CmpLatency(3), .MaxCycles(64)) dut3 (
        .clk_i(clk), .rst_i(rst), .vin_i(vin), .sample_i(sample), .dac_i(dac),
        .eoc_i(eoc), .result_i(result), .cmp_o(cmp3), .held_o(held3), .busy_o(busy3),
        .match_o(match3), .mismatch_o(mismatch3), .timeout_o(timeout3), .err_cnt_o(err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] kind, input string name);
        exp_t x;
        if (kind != K_MATCH && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        x.kind = kind;
        x.err  = exp_err;
        x.name = name;
        exp_q.push_back(x);
    endtask

    // track v for two cycles, then drop sample; returns with the DUT in HOLD
    task automatic do_hold(input logic [W-1:0] v, input string name);
        vin = v;
        sample = 1'b1;
        tick();
        tick();
        sample = 1'b0;
        tick();
        check({name, "_busy"}, busy, 1);
        check({name, "_held"}, held, v);
    endtask

    task automatic cmp_check(input logic [W-1:0] d, input logic e_cmp, input string name);
        dac = d;
        tick();
        check(name, cmp, e_cmp);
    endtask

    task automatic sar_search(output logic [W-1:0] c);
        logic [W-1:0] trial;
        c = '0;
        for (int b = W - 1; b >= 0; b--) begin
            trial = c | (W'(1) << b);
            dac = trial;
            tick();
            if (cmp) c = trial;
        end
    endtask

    task automatic finish_conv(input logic [W-1:0] r, input logic [2:0] kind, input string name);
        push(kind, name);
        result = r;
        eoc = 1'b1;
        tick();
        tick();
        eoc = 1'b0;
        tick();
    endtask

    task automatic convert(input logic [W-1:0] v, input string name);
        logic [W-1:0] c;
        do_hold(v, name);
        sar_search(c);
        check({name, "_code"}, c, v);
        finish_conv(c, K_MATCH, name);
    endtask

    // scoreboard monitor: every pulse must match the head of the expectation queue
    always @(negedge clk) begin
        if (!rst && (match || mismatch || timeout)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, timeout, mismatch, match}, 0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_pulse"}, {29'd0, timeout, mismatch, match}, {29'd0, e.kind});
                check({e.name, "_errcnt"}, err_cnt, e.err);
            end
        end
    end

    initial begin
        rst = 1'b1; vin = '0; dac = '0; result = '0; sample = 1'b0; eoc = 1'b0; exp_err = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmp", cmp, 0);
        check("rst_held", held, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {match, mismatch, timeout}, 0);
        check("rst_err", err_cnt, 0);
        check("rst_cmp3", cmp3, 0);
        rst = 1'b0;
        tick();

        // full conversion with the SAR search in the loop
        convert(6'd37, "conv37");
        check("err_after37", err_cnt, 0);

        // code range ends, back to back, with comparator boundaries
        do_hold(6'd0, "h0");
        cmp_check(6'd0, 1'b1, "cmp_h0_d0");
        cmp_check(6'd1, 1'b0, "cmp_h0_d1");
        sar_search(code);
        check("h0_code", code, 0);
        finish_conv(code, K_MATCH, "conv0");
        do_hold(6'd63, "h63");
        cmp_check(6'd63, 1'b1, "cmp_h63_d63");
        sar_search(code);
        check("h63_code", code, 63);
        finish_conv(code, K_MATCH, "conv63");
        do_hold(6'd62, "h62");
        cmp_check(6'd63, 1'b0, "cmp_h62_d63");

        // abort by raising sample in HOLD: silent
        sample = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_cmp", cmp, 0);
        tick();
        check("abort_err", err_cnt, 0);

        // eoc rise and sample rise together: CHECK wins
        do_hold(6'd15, "h15");
        result = 6'd15;
        push(K_MATCH, "prio");
        eoc = 1'b1;
        sample = 1'b1;
        tick();
        tick();
        eoc = 1'b0;
        sample = 1'b0;
        tick();

        // wrong result
        do_hold(6'd20, "h20");
        finish_conv(6'd21, K_MIS, "mis21");
        check("err_after_mis", err_cnt, 1);

        // timeout after 64 HOLD cycles
        do_hold(6'd9, "h9");
        repeat (63) tick();
        check("to_busy_pre", busy, 1);
        check("to_pulse_pre", timeout, 0);
        push(K_TO, "timeout");
        tick();
        check("to_busy_post", busy, 0);
        check("to_pulse", timeout, 1);
        tick();
        check("err_after_to", err_cnt, 2);

        // 3-cycle comparator delay on the second instance
        do_hold(6'd30, "h30");
        dac = 6'd10;
        repeat (3) tick();
        check("l3_dac10", cmp3, 1);
        dac = 6'd40;
        tick();
        check("l1_dac40", cmp, 0);
        check("l3_d1", cmp3, 1);
        tick();
        check("l3_d2", cmp3, 1);
        tick();
        check("l3_d3", cmp3, 0);

        // asynchronous reset in HOLD
        rst = 1'b1;
        #1;
        exp_err = '0;
        check("mrst_cmp", cmp, 0);
        check("mrst_held", held, 0);
        check("mrst_busy", busy, 0);
        check("mrst_pulses", {match, mismatch, timeout}, 0);
        check("mrst_err", err_cnt, 0);
        check("mrst_busy3", busy3, 0);
        check("mrst_held3", held3, 0);
        tick();
        rst = 1'b0;
        tick();
        convert(6'd44, "post_rst");
        check("err_post_rst", err_cnt, 0);

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
